al422_frame_reader: RTL and testbench
=====================================

Name: al422_frame_reader

Overview:
- Capture sequencer between the stereo camera breakout (MT9V034 + AL422B FIFOs) and the left/right image BRAMs that feed the disparity engine.
- On `start` it does the following, then signals `done` so disparity can begin:
  - triggers both cameras and waits for the frames to land in the FIFOs;
  - read-resets and streams each AL422B in turn (left, then right);
  - crops the source frame to the processing window and writes each cropped pixel to the matching image BRAM.
- Runs entirely in the FIFO read-clock domain: `clk` is also driven out as FIFO_RCK.

Parameters:
- SRC_W, 752, source pixels per row stored in the FIFO
- SRC_H, 480, source rows per frame
- IMG_W, 384, cropped output width
- IMG_H, 288, cropped output height
- X_START, 184, first source column kept
- Y_START, 96, first source row kept
- TRIG_CYCLES, 8, trigger high time in clk cycles
- FRAME_WAIT, 200000, clk cycles from trigger fall to FIFO read start
- RRST_CYCLES, 4, fifo_rrst low time before streaming

Ports:
- clk  in  1  FIFO read clock (5 MHz), also drives AL422B RCK
- reset  in  1  asynchronous, active-low reset
- start  in  1  level or pulse; begin capture when idle
- fifo_data  in  8  AL422B DO[7:0], shared by both FIFOs
- trigger  out  1  camera trigger, active high
- image_sel  out  1  0 = left FIFO, 1 = right FIFO
- fifo_rrst  out  1  AL422B read reset, active low
- fifo_oe  out  1  AL422B output/read enable, active low
- img_waddr  out  17  image BRAM write address, 0..IMG_W*IMG_H-1
- img_wdata  out  8  pixel data
- img_wen_l  out  1  left image BRAM write enable
- img_wen_r  out  1  right image BRAM write enable
- busy  out  1  high from accept of start until done
- done  out  1  one-cycle pulse when both images are written

Behaviour:
- Reset values (async, reset=0), also returned to on reset mid-operation from any state:
  - trigger=0, image_sel=0, fifo_rrst=1, fifo_oe=1
  - img_waddr=0, img_wdata=0, img_wen_l=0, img_wen_r=0
  - busy=0, done=0, state=IDLE, all counters 0
- FSM states: IDLE, TRIG, WAIT, RRST, READ, NEXT, DONE.
- IDLE:
  - start=1 -> TRIG; busy goes 1 on the next edge.
  - start while busy is ignored.
- TRIG: trigger=1 for exactly TRIG_CYCLES cycles -> WAIT.
- WAIT: count FRAME_WAIT cycles with trigger=0 -> RRST.
- RRST:
  - fifo_rrst=0 for exactly RRST_CYCLES cycles, fifo_oe=1.
  - Then -> READ; src_col, src_row and img_waddr are cleared.
- READ:
  - fifo_oe=0 for exactly SRC_W*SRC_H cycles; one source pixel per cycle.
  - AL422B data is valid one clk after the OE-low edge that requests it, so the pixel position (src_col, src_row) is delayed one stage alongside the data.
  - A pixel is kept when X_START <= col < X_START+IMG_W and Y_START <= row < Y_START+IMG_H.
  - For a kept pixel, register img_wdata=fifo_data and pulse the write enable selected by image_sel for one cycle.
  - img_waddr increments by 1 after each write; it is never recomputed with a multiplier.
  - src_col wraps SRC_W-1 -> 0 and increments src_row.
  - After the last OE-low cycle, the final pipelined write still completes; then -> NEXT.
- NEXT:
  - image_sel=0 -> set image_sel=1, then -> RRST.
  - image_sel=1 -> DONE.
- DONE:
  - done=1 for one cycle, busy=0, image_sel=0, fifo_oe=1 -> IDLE.
  - start asserted in the same cycle as done is ignored; it is accepted from the following cycle.
- Invariants:
  - image_sel changes only while fifo_oe=1 and fifo_rrst=1.
  - At most one of img_wen_l/img_wen_r is high in any cycle.
  - Exactly IMG_W*IMG_H writes per image; the last img_waddr written is IMG_W*IMG_H-1.
- Parameter bounds: X_START+IMG_W <= SRC_W and Y_START+IMG_H <= SRC_H. This is checked by a simulation-only assertion.

Test Plan:
1. Reset mid-READ: assert reset=0 partway through a read -> same cycle: fifo_oe=1, fifo_rrst=1, wens=0, busy=0. After release with no start, outputs stay idle for 100 cycles.
2. Small parameters (SRC 8x6, IMG 4x3, X_START=2, Y_START=1), FIFO model returns value = source index:
   - left writes addr 0..11 with data 10,11,12,13,18,19,20,21,26,27,28,29;
   - then identical addresses on img_wen_r;
   - done pulses once.
3. Control timing: trigger high exactly TRIG_CYCLES=8 cycles; FIFO read starts exactly FRAME_WAIT cycles after trigger falls; fifo_rrst low exactly 4 cycles before each image; fifo_oe low exactly 48 cycles per image.
4. Pipeline alignment: FIFO model with 1-cycle latency; first written byte equals source pixel (X_START,Y_START), not its neighbour.
5. Protocol:
   - start held high continuously -> back-to-back captures, with a minimum of one IDLE cycle between done and the next trigger;
   - a start pulse during WAIT does not restart or extend the sequence.
6. Default parameters, one full run:
   - 110592 left writes, then 110592 right writes, final img_waddr = 110591;
   - image_sel toggles only while fifo_oe=1.

Source files
------------

// File: rtl/al422_frame_reader.sv
// Stereo capture sequencer: triggers both cameras, read-resets and streams each AL422B FIFO,
// and writes the cropped window into the left/right image BRAMs, all on the FIFO read clock.
module al422_frame_reader #(
    parameter int SRC_W       = 752,
    parameter int SRC_H       = 480,
    parameter int IMG_W       = 384,
    parameter int IMG_H       = 288,
    parameter int X_START     = 184,
    parameter int Y_START     = 96,
    parameter int TRIG_CYCLES = 8,
    parameter int FRAME_WAIT  = 200000,
    parameter int RRST_CYCLES = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [7:0]  fifo_data_i,
    output logic        trigger_o,
    output logic        image_sel_o,
    output logic        fifo_rrst_o,
    output logic        fifo_oe_o,
    output logic [16:0] img_waddr_o,
    output logic [7:0]  img_wdata_o,
    output logic        img_wen_l_o,
    output logic        img_wen_r_o,
    output logic        busy_o,
    output logic        done_o
);

    localparam int          CW    = $clog2(SRC_W + 1);
    localparam int          RW    = $clog2(SRC_H + 1);
    localparam logic [31:0] PIX_N = 32'(SRC_W * SRC_H);

    typedef enum logic [2:0] {IDLE, TRIG, WAIT, RRST, READ, NEXT, DONE} state_t;

    state_t          state_q, state_d;
    logic [31:0]     cnt_q, cnt_d;
    logic            sel_q, sel_d;
    logic            clr_pos;
    logic            rd_en;
    logic [CW-1:0]   src_col_q;
    logic [RW-1:0]   src_row_q;
    logic            p1_vld_q;
    logic [CW-1:0]   p1_col_q;
    logic [RW-1:0]   p1_row_q;
    logic            keep;
    logic [16:0]     wptr_q;
    logic [16:0]     waddr_q;
    logic [7:0]      wdata_q;
    logic            wen_l_q, wen_r_q;
    logic            trig_q, rrst_q, oe_q, busy_q, done_q;
    logic            trig_d, rrst_d, oe_d, busy_d, done_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 32'd1;
        sel_d   = sel_q;
        clr_pos = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (start_i) state_d = TRIG;
            end
            TRIG: if (cnt_q == 32'(TRIG_CYCLES - 1)) begin
                state_d = WAIT;
                cnt_d   = '0;
            end
            WAIT: if (cnt_q == 32'(FRAME_WAIT - 1)) begin
                state_d = RRST;
                cnt_d   = '0;
            end
            RRST: if (cnt_q == 32'(RRST_CYCLES - 1)) begin
                state_d = READ;
                cnt_d   = '0;
                clr_pos = 1'b1;
            end
            // One extra cycle after the last OE-low cycle lets the final pixel land.
            READ: if (cnt_q == PIX_N) begin
                state_d = NEXT;
                cnt_d   = '0;
            end
            NEXT: begin
                cnt_d = '0;
                if (!sel_q) begin
                    sel_d   = 1'b1;
                    state_d = RRST;
                end else begin
                    sel_d   = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase

        trig_d = (state_d == TRIG);
        rrst_d = (state_d != RRST);
        oe_d   = !((state_d == READ) && (cnt_d < PIX_N));
        busy_d = state_d inside {TRIG, WAIT, RRST, READ, NEXT};
        done_d = (state_d == DONE);
    end

    assign rd_en = (state_q == READ) && (cnt_q < PIX_N);

    // Position of the pixel currently on fifo_data_i (one clk behind the OE request).
    assign keep = p1_vld_q
               && (p1_col_q >= CW'(X_START)) && (p1_col_q < CW'(X_START + IMG_W))
               && (p1_row_q >= RW'(Y_START)) && (p1_row_q < RW'(Y_START + IMG_H));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sel_q   <= 1'b0;
            trig_q  <= 1'b0;
            rrst_q  <= 1'b1;
            oe_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            trig_q  <= trig_d;
            rrst_q  <= rrst_d;
            oe_q    <= oe_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            src_col_q <= '0;
            src_row_q <= '0;
            p1_vld_q  <= 1'b0;
            p1_col_q  <= '0;
            p1_row_q  <= '0;
        end else begin
            p1_vld_q <= rd_en;
            p1_col_q <= src_col_q;
            p1_row_q <= src_row_q;
            if (clr_pos) begin
                src_col_q <= '0;
                src_row_q <= '0;
            end else if (rd_en) begin
                if (src_col_q == CW'(SRC_W - 1)) begin
                    src_col_q <= '0;
                    src_row_q <= src_row_q + RW'(1);
                end else begin
                    src_col_q <= src_col_q + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
            wen_l_q <= 1'b0;
            wen_r_q <= 1'b0;
        end else begin
            wen_l_q <= keep && !sel_q;
            wen_r_q <= keep && sel_q;
            if (clr_pos) begin
                wptr_q  <= '0;
                waddr_q <= '0;
            end else if (keep) begin
                wdata_q <= fifo_data_i;
                waddr_q <= wptr_q;
                wptr_q  <= wptr_q + 17'd1;
            end
        end
    end

    assign trigger_o   = trig_q;
    assign image_sel_o = sel_q;
    assign fifo_rrst_o = rrst_q;
    assign fifo_oe_o   = oe_q;
    assign img_waddr_o = waddr_q;
    assign img_wdata_o = wdata_q;
    assign img_wen_l_o = wen_l_q;
    assign img_wen_r_o = wen_r_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

    a_crop_fits: assert property (@(posedge clk_i)
        (X_START + IMG_W <= SRC_W) && (Y_START + IMG_H <= SRC_H));
    a_one_wen: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(img_wen_l_o && img_wen_r_o));

endmodule

// File: tb/tb_al422_frame_reader.sv
// Bench for al422_frame_reader with a reduced 8x6 source / 4x3 window and an AL422B read model.
module tb_al422_frame_reader;

    localparam int SRC_W = 8, SRC_H = 6, IMG_W = 4, IMG_H = 3, X_START = 2, Y_START = 1;
    localparam int TRIG_CYCLES = 8, FRAME_WAIT = 20, RRST_CYCLES = 4;
    localparam int NPIX   = SRC_W * SRC_H;
    localparam int BUDGET = 1000;

    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [7:0]  fifo_data = 8'd0;
    logic        trigger, image_sel, fifo_rrst, fifo_oe, img_wen_l, img_wen_r, busy, done;
    logic [16:0] img_waddr;
    logic [7:0]  img_wdata;
    logic [16:0] rd_ptr = 17'd0;
    logic [32:0] outs;

    localparam logic [32:0] IDLE_V = {1'b0, 1'b0, 1'b1, 1'b1, 17'd0, 8'd0, 4'b0000};

    typedef struct packed {logic sel; logic [16:0] addr; logic [7:0] data;} wr_t;
    wr_t exp_q[$];

    int n_cmp = 0, n_bad = 0;

    al422_frame_reader #(
        .SRC_W(SRC_W), .SRC_H(SRC_H), .IMG_W(IMG_W), .IMG_H(IMG_H),
        .X_START(X_START), .Y_START(Y_START), .TRIG_CYCLES(TRIG_CYCLES),
        .FRAME_WAIT(FRAME_WAIT), .RRST_CYCLES(RRST_CYCLES)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .fifo_data_i(fifo_data),
        .trigger_o(trigger), .image_sel_o(image_sel), .fifo_rrst_o(fifo_rrst),
        .fifo_oe_o(fifo_oe), .img_waddr_o(img_waddr), .img_wdata_o(img_wdata),
        .img_wen_l_o(img_wen_l), .img_wen_r_o(img_wen_r), .busy_o(busy), .done_o(done)
    );

    assign outs = {trigger, image_sel, fifo_rrst, fifo_oe, img_waddr, img_wdata,
                   img_wen_l, img_wen_r, busy, done};

    always #5 clk = ~clk;

    // AL422B model: the byte requested by an OE-low edge appears after that edge.
    // Left frame holds its source index, right frame the index + 100.
    always @(posedge clk) begin
        if (!fifo_rrst) rd_ptr <= 17'd0;
        else if (!fifo_oe) begin
            fifo_data <= 8'(rd_ptr) + (image_sel ? 8'd100 : 8'd0);
            rd_ptr    <= rd_ptr + 17'd1;
        end
    end

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (outs !== IDLE_V) begin n_bad++; $display("FAIL reset_values: got %h want %h", outs, IDLE_V); end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (outs !== IDLE_V) begin n_bad++; $display("FAIL idle_after_release: got %h want %h", outs, IDLE_V); end
    endtask

    task automatic test_capture();
        int  done_cnt = 0, post = 0;
        logic prev_sel = 1'b0, prev_oe = 1'b1, prev_rrst = 1'b1;
        wr_t e, got;
        for (int s = 0; s < 2; s++)
            for (int r = 0; r < IMG_H; r++)
                for (int c = 0; c < IMG_W; c++) begin
                    e.sel  = s[0];
                    e.addr = 17'(r * IMG_W + c);
                    e.data = 8'((Y_START + r) * SRC_W + X_START + c + s * 100);
                    exp_q.push_back(e);
                end
        start = 1'b1;
        for (int k = 0; k < BUDGET && post < 4; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (img_wen_l || img_wen_r) begin
                got = {img_wen_r, img_waddr, img_wdata};
                n_cmp++;
                if (img_wen_l && img_wen_r) begin
                    n_bad++; $display("FAIL both_wen: got wen_l=1 wen_r=1 want at most one");
                end else if (exp_q.size() == 0) begin
                    n_bad++; $display("FAIL extra_write: got sel/addr/data %h want no write", got);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        n_bad++; $display("FAIL write: got sel=%0d addr=%0d data=%0d want sel=%0d addr=%0d data=%0d",
                                          got.sel, got.addr, got.data, e.sel, e.addr, e.data);
                    end
                end
            end
            if (image_sel !== prev_sel) begin
                n_cmp++;
                if (!(prev_oe && prev_rrst && fifo_oe)) begin
                    n_bad++; $display("FAIL sel_change: got oe=%0d/%0d rrst=%0d want oe=1 rrst=1", prev_oe, fifo_oe, prev_rrst);
                end
            end
            prev_sel = image_sel; prev_oe = fifo_oe; prev_rrst = fifo_rrst;
            if (done) done_cnt++;
            if (done_cnt > 0) post++;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin n_bad++; $display("FAIL missing_writes: got %0d left want 0", exp_q.size()); end
        n_cmp++;
        if (done_cnt != 1) begin n_bad++; $display("FAIL done_pulses: got %0d want 1", done_cnt); end
        n_cmp++;
        if (img_waddr !== 17'(IMG_W * IMG_H - 1)) begin
            n_bad++; $display("FAIL final_addr: got %0d want %0d", img_waddr, IMG_W * IMG_H - 1);
        end
        exp_q.delete();
    endtask

    task automatic test_timing();
        int trig_cnt = 0, wait_len = -1, since_fall = 0, run = 0, orun = 0;
        int rrst_runs[$], oe_runs[$];
        logic prev_trig = 1'b0, fell = 1'b0, seen_done = 1'b0;
        start = 1'b1;
        for (int k = 0; k < BUDGET && !seen_done; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (trigger) trig_cnt++;
            if (prev_trig && !trigger) fell = 1'b1;
            if (fell && wait_len < 0) begin
                if (!fifo_rrst) wait_len = since_fall;
                else since_fall++;
            end
            if (!fifo_rrst) run++;
            else if (run > 0) begin rrst_runs.push_back(run); run = 0; end
            if (!fifo_oe) orun++;
            else if (orun > 0) begin oe_runs.push_back(orun); orun = 0; end
            prev_trig = trigger;
            if (done) seen_done = 1'b1;
        end
        n_cmp++;
        if (!seen_done) begin n_bad++; $display("FAIL timing_done: got no done want done"); end
        n_cmp++;
        if (trig_cnt != TRIG_CYCLES) begin n_bad++; $display("FAIL trig_len: got %0d want %0d", trig_cnt, TRIG_CYCLES); end
        n_cmp++;
        if (wait_len != FRAME_WAIT) begin n_bad++; $display("FAIL frame_wait: got %0d want %0d", wait_len, FRAME_WAIT); end
        n_cmp++;
        if (rrst_runs.size() != 2 || rrst_runs[0] != RRST_CYCLES || rrst_runs[1] != RRST_CYCLES) begin
            n_bad++; $display("FAIL rrst_len: got %0d runs want 2 runs of %0d", rrst_runs.size(), RRST_CYCLES);
        end
        n_cmp++;
        if (oe_runs.size() != 2 || oe_runs[0] != NPIX || oe_runs[1] != NPIX) begin
            n_bad++; $display("FAIL oe_len: got %0d runs want 2 runs of %0d", oe_runs.size(), NPIX);
        end
    endtask

    task automatic test_protocol();
        int done_cyc = -1, rise_cyc = -1, dones = 0, first = -1, dcyc = -1, rises = 0;
        logic prev_trig = 1'b0;
        start = 1'b1;
        for (int k = 0; k < BUDGET && dones < 2; k++) begin
            @(negedge clk);
            if (done) begin
                dones++;
                n_cmp++;
                if (busy !== 1'b0) begin n_bad++; $display("FAIL busy_at_done: got %0d want 0", busy); end
                if (dones == 1) done_cyc = k;
            end
            if (trigger && !prev_trig && done_cyc >= 0 && rise_cyc < 0) rise_cyc = k;
            prev_trig = trigger;
        end
        start = 1'b0;
        n_cmp++;
        if (dones != 2) begin n_bad++; $display("FAIL held_start_dones: got %0d want 2", dones); end
        n_cmp++;
        if (rise_cyc - done_cyc != 2) begin
            n_bad++; $display("FAIL done_to_trigger: got %0d want 2", rise_cyc - done_cyc);
        end
        repeat (3) @(negedge clk);

        prev_trig = 1'b0;
        start = 1'b1;
        for (int k = 0; k < BUDGET && dcyc < 0; k++) begin
            @(negedge clk);
            start = (k == 14);
            if (trigger && !prev_trig) begin rises++; if (first < 0) first = k; end
            if (done) dcyc = k;
            prev_trig = trigger;
        end
        start = 1'b0;
        n_cmp++;
        if (rises != 1) begin n_bad++; $display("FAIL wait_start_retrigger: got %0d triggers want 1", rises); end
        n_cmp++;
        if (dcyc - first != TRIG_CYCLES + FRAME_WAIT + 2 * (RRST_CYCLES + NPIX + 2)) begin
            n_bad++; $display("FAIL wait_start_length: got %0d want %0d", dcyc - first,
                              TRIG_CYCLES + FRAME_WAIT + 2 * (RRST_CYCLES + NPIX + 2));
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int k = 0, bad = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (fifo_oe && k < BUDGET) begin @(negedge clk); k++; end
        n_cmp++;
        if (fifo_oe) begin n_bad++; $display("FAIL reset_mid_reach_read: got oe=1 want oe=0"); end
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (outs !== IDLE_V) begin n_bad++; $display("FAIL reset_mid_same_cycle: got %h want %h", outs, IDLE_V); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (100) begin
            @(negedge clk);
            if (outs !== IDLE_V) bad++;
        end
        n_cmp++;
        if (bad != 0) begin n_bad++; $display("FAIL idle_after_mid_reset: got %0d busy cycles want 0", bad); end
    endtask

    initial begin
        test_reset();
        test_capture();
        test_timing();
        test_protocol();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
